// File: rtl/branch_resolve_pkg.sv
// Shared definitions for branch resolution: op-code encodings, the
// output-register FSM state encodings and a decode helper.
package branch_resolve_pkg;

   localparam logic [3:0] OP_NONE = 4'd0;
   localparam logic [3:0] OP_BEQ  = 4'd1;
   localparam logic [3:0] OP_BNE  = 4'd2;
   localparam logic [3:0] OP_BLT  = 4'd3;
   localparam logic [3:0] OP_BGE  = 4'd4;
   localparam logic [3:0] OP_BLTU = 4'd5;
   localparam logic [3:0] OP_BGEU = 4'd6;
   localparam logic [3:0] OP_JAL  = 4'd7;
   localparam logic [3:0] OP_JALR = 4'd8;

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

   // Only the six conditional branches feed the statistics counters.
   function automatic logic isCondBranch(input logic [3:0] op);
      return (op >= OP_BEQ) && (op <= OP_BGEU);
   endfunction

endpackage

// File: rtl/branch_resolve_if.sv
// Request/result handshake bundle between the issue stage (master) and
// the branch resolution unit (slave).
interface branch_resolve_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [3:0]      in_op;
   logic [XLEN-1:0] in_pc;
   logic [XLEN-1:0] in_rs1;
   logic [XLEN-1:0] in_rs2;
   logic [XLEN-1:0] in_imm;
   logic            flush;
   logic            out_valid;
   logic            out_ready;
   logic            out_taken;
   logic [XLEN-1:0] out_target;
   logic [XLEN-1:0] out_link;
   logic            out_misaligned;

   modport master (
      output in_valid, in_op, in_pc, in_rs1, in_rs2, in_imm, flush, out_ready,
      input  in_ready, out_valid, out_taken, out_target, out_link, out_misaligned
   );

   modport slave (
      input  in_valid, in_op, in_pc, in_rs1, in_rs2, in_imm, flush, out_ready,
      output in_ready, out_valid, out_taken, out_target, out_link, out_misaligned
   );
endinterface

// File: rtl/branch_resolve_cond.sv
// Purely combinational branch condition evaluation and next-PC calculation.
module branch_cond
   import branch_resolve_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int IALIGN = 32
) (
   input  logic [3:0]      op_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic [XLEN-1:0] imm_i,
   output logic            taken_o,
   output logic [XLEN-1:0] target_o,
   output logic [XLEN-1:0] link_o,
   output logic            misaligned_o,
   output logic            isBranch_o
);

   logic [XLEN-1:0] jalrTarget;

   always_comb begin
      taken_o = 1'b0;
      case (op_i)
         OP_BEQ:           taken_o = (rs1_i == rs2_i);
         OP_BNE:           taken_o = (rs1_i != rs2_i);
         OP_BLT:           taken_o = ($signed(rs1_i) <  $signed(rs2_i));
         OP_BGE:           taken_o = ($signed(rs1_i) >= $signed(rs2_i));
         OP_BLTU:          taken_o = (rs1_i <  rs2_i);
         OP_BGEU:          taken_o = (rs1_i >= rs2_i);
         OP_JAL, OP_JALR:  taken_o = 1'b1;
         default:          taken_o = 1'b0;
      endcase
   end

   assign link_o     = pc_i + XLEN'(4);
   assign jalrTarget = (rs1_i + imm_i) & ~XLEN'(1);

   always_comb begin
      target_o = link_o;
      if (taken_o) begin
         target_o = (op_i == OP_JALR) ? jalrTarget : (pc_i + imm_i);
      end
   end

   // With compressed instructions enabled every halfword target is legal.
   assign misaligned_o = (IALIGN == 32) ? (taken_o & target_o[1]) : 1'b0;
   assign isBranch_o   = isCondBranch(op_i);

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution unit: one-entry result register with valid/ready
// handshake, flush support and saturating branch statistics.
module branch_resolve
   import branch_resolve_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int IALIGN = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   branch_resolve_if.slave   bus,
   output logic [CNT_W-1:0]  stat_branches,
   output logic [CNT_W-1:0]  stat_taken
);

   logic [0:0]       state_q, state_d;
   logic             taken_q, taken_d;
   logic             misaligned_q, misaligned_d;
   logic [XLEN-1:0]  target_q, target_d;
   logic [XLEN-1:0]  link_q, link_d;
   logic [CNT_W-1:0] statBranches_q, statBranches_d;
   logic [CNT_W-1:0] statTaken_q, statTaken_d;

   logic             condTaken, condMisaligned, condIsBranch;
   logic [XLEN-1:0]  condTarget, condLink;
   logic             accept;

   branch_cond #(
      .XLEN   (XLEN),
      .IALIGN (IALIGN)
   ) uCond (
      .op_i         (bus.in_op),
      .pc_i         (bus.in_pc),
      .rs1_i        (bus.in_rs1),
      .rs2_i        (bus.in_rs2),
      .imm_i        (bus.in_imm),
      .taken_o      (condTaken),
      .target_o     (condTarget),
      .link_o       (condLink),
      .misaligned_o (condMisaligned),
      .isBranch_o   (condIsBranch)
   );

   // Reset forces ready so upstream never stalls against a stale FULL state.
   assign bus.out_valid = (state_q == ST_FULL);
   assign bus.in_ready  = rst || !bus.out_valid || bus.out_ready;
   assign accept        = bus.in_valid && bus.in_ready && !bus.flush;

   always_comb begin
      state_d        = state_q;
      taken_d        = taken_q;
      misaligned_d   = misaligned_q;
      target_d       = target_q;
      link_d         = link_q;
      statBranches_d = statBranches_q;
      statTaken_d    = statTaken_q;
      if (bus.flush) begin
         state_d = ST_EMPTY;
      end else if (accept) begin
         state_d      = ST_FULL;
         taken_d      = condTaken;
         misaligned_d = condMisaligned;
         target_d     = condTarget;
         link_d       = condLink;
         if (condIsBranch) begin
            if (statBranches_q != {CNT_W{1'b1}}) statBranches_d = statBranches_q + 1'b1;
            if (condTaken && (statTaken_q != {CNT_W{1'b1}})) statTaken_d = statTaken_q + 1'b1;
         end
      end else if (bus.out_ready) begin
         state_d = ST_EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_EMPTY;
         taken_q        <= 1'b0;
         misaligned_q   <= 1'b0;
         target_q       <= '0;
         link_q         <= '0;
         statBranches_q <= '0;
         statTaken_q    <= '0;
      end else begin
         state_q        <= state_d;
         taken_q        <= taken_d;
         misaligned_q   <= misaligned_d;
         target_q       <= target_d;
         link_q         <= link_d;
         statBranches_q <= statBranches_d;
         statTaken_q    <= statTaken_d;
      end
   end

   assign bus.out_taken      = taken_q;
   assign bus.out_target     = target_q;
   assign bus.out_link       = link_q;
   assign bus.out_misaligned = misaligned_q;
   assign stat_branches      = statBranches_q;
   assign stat_taken         = statTaken_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench: two DUTs (CNT_W=16 and CNT_W=2) share one stimulus
// stream and are compared every cycle against a behavioural model.
module tb_branch_resolve;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        inValid = 1'b0;
   logic [3:0]  inOp = 4'd0;
   logic [31:0] inPc = '0, inRs1 = '0, inRs2 = '0, inImm = '0;
   logic        flushIn = 1'b0;
   logic        outReady = 1'b0;

   logic [15:0] statBrA, statTkA;
   logic [1:0]  statBrB, statTkB;

   int checks = 0;
   int errors = 0;

   branch_resolve_if #(.XLEN(32)) busA ();
   branch_resolve_if #(.XLEN(32)) busB ();

   assign busA.in_valid = inValid;  assign busB.in_valid = inValid;
   assign busA.in_op    = inOp;     assign busB.in_op    = inOp;
   assign busA.in_pc    = inPc;     assign busB.in_pc    = inPc;
   assign busA.in_rs1   = inRs1;    assign busB.in_rs1   = inRs1;
   assign busA.in_rs2   = inRs2;    assign busB.in_rs2   = inRs2;
   assign busA.in_imm   = inImm;    assign busB.in_imm   = inImm;
   assign busA.flush    = flushIn;  assign busB.flush    = flushIn;
   assign busA.out_ready = outReady; assign busB.out_ready = outReady;

   branch_resolve #(.XLEN(32), .IALIGN(32), .CNT_W(16)) dutA (
      .clk(clk), .rst(rst), .bus(busA), .stat_branches(statBrA), .stat_taken(statTkA)
   );

   branch_resolve #(.XLEN(32), .IALIGN(32), .CNT_W(2)) dutB (
      .clk(clk), .rst(rst), .bus(busB), .stat_branches(statBrB), .stat_taken(statTkB)
   );

   always #5 clk = ~clk;

   // Reference semantics of each op, straight from the ISA rules.
   function automatic bit refTaken(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         4'd1: return a == b;
         4'd2: return a != b;
         4'd3: return $signed(a) <  $signed(b);
         4'd4: return $signed(a) >= $signed(b);
         4'd5: return a <  b;
         4'd6: return a >= b;
         4'd7, 4'd8: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] refTarget(input logic [3:0] op, input logic [31:0] pc,
                                             input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] imm);
      if (op == 4'd8) return (a + imm) & 32'hFFFF_FFFE;
      if (refTaken(op, a, b)) return pc + imm;
      return pc + 32'd4;
   endfunction

   function automatic bit refMis(input logic [3:0] op, input logic [31:0] pc,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] imm);
      logic [31:0] t;
      t = refTarget(op, pc, a, b, imm);
      return refTaken(op, a, b) && t[1];
   endfunction

   function automatic int satInc(input int v, input int mx);
      return (v < mx) ? v + 1 : v;
   endfunction

   bit          started = 1'b0;
   bit          mValid = 1'b0, mZero = 1'b0, mTaken = 1'b0, mMis = 1'b0;
   logic [31:0] mTarget = '0, mLink = '0;
   int          mBrA = 0, mTkA = 0, mBrB = 0, mTkB = 0;

   // Model of the one-entry result holder and the counters.
   always @(posedge clk) begin
      if (rst) begin
         started <= 1'b1;
         mValid  <= 1'b0;
         mZero   <= 1'b1;
         mTaken  <= 1'b0;
         mTarget <= '0;
         mLink   <= '0;
         mMis    <= 1'b0;
         mBrA <= 0; mTkA <= 0; mBrB <= 0; mTkB <= 0;
      end else if (flushIn) begin
         mValid <= 1'b0;
      end else if (inValid && (!mValid || outReady)) begin
         mValid  <= 1'b1;
         mZero   <= 1'b0;
         mTaken  <= refTaken(inOp, inRs1, inRs2);
         mTarget <= refTarget(inOp, inPc, inRs1, inRs2, inImm);
         mLink   <= inPc + 32'd4;
         mMis    <= refMis(inOp, inPc, inRs1, inRs2, inImm);
         if (inOp >= 4'd1 && inOp <= 4'd6) begin
            mBrA <= satInc(mBrA, 65535);
            mBrB <= satInc(mBrB, 3);
            if (refTaken(inOp, inRs1, inRs2)) begin
               mTkA <= satInc(mTkA, 65535);
               mTkB <= satInc(mTkB, 3);
            end
         end
      end else if (outReady) begin
         mValid <= 1'b0;
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   always @(negedge clk) begin
      if (started) begin
         checkOutput("in_ready",  64'(busA.in_ready), 64'(rst || !mValid || outReady));
         checkOutput("in_readyB", 64'(busB.in_ready), 64'(rst || !mValid || outReady));
         checkOutput("out_valid",  64'(busA.out_valid), 64'(mValid));
         checkOutput("out_validB", 64'(busB.out_valid), 64'(mValid));
         if (mValid || mZero) begin
            checkOutput("taken",  64'(busA.out_taken),      64'(mTaken));
            checkOutput("target", 64'(busA.out_target),     64'(mTarget));
            checkOutput("link",   64'(busA.out_link),       64'(mLink));
            checkOutput("mis",    64'(busA.out_misaligned), 64'(mMis));
            checkOutput("takenB", 64'(busB.out_taken),      64'(mTaken));
            checkOutput("targetB", 64'(busB.out_target),    64'(mTarget));
         end
         checkOutput("statBrA", 64'(statBrA), 64'(mBrA));
         checkOutput("statTkA", 64'(statTkA), 64'(mTkA));
         checkOutput("statBrB", 64'(statBrB), 64'(mBrB));
         checkOutput("statTkB", 64'(statTkB), 64'(mTkB));
      end
   end

   // Inputs change 2 time units after a rising edge and are consumed at the next one.
   task automatic applyStimulus(input bit r, input bit v, input logic [3:0] op,
                                input logic [31:0] pc, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] imm,
                                input bit rdy, input bit fl);
      @(posedge clk);
      #2;
      rst = r; inValid = v; inOp = op; inPc = pc; inRs1 = a; inRs2 = b;
      inImm = imm; outReady = rdy; flushIn = fl;
      #1;
   endtask

   task automatic idle(input bit rdy);
      applyStimulus(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0, rdy, 1'b0);
   endtask

   initial begin
      logic [31:0] a, b, imm, pc, r;
      // Reset, with a request presented during reset that must be dropped.
      applyStimulus(1'b1, 1'b1, 4'd1, 32'h80, 32'h5, 32'h5, 32'h8, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      checkOutput("lit_rst_in_ready", 64'(busA.in_ready), 64'd1);
      idle(1'b1);
      checkOutput("lit_rst_valid",  64'(busA.out_valid),  64'd0);
      checkOutput("lit_rst_target", 64'(busA.out_target), 64'd0);
      checkOutput("lit_rst_link",   64'(busA.out_link),   64'd0);
      checkOutput("lit_rst_br",     64'(statBrA),         64'd0);

      // Signed vs unsigned less-than on the same operands.
      applyStimulus(1'b0, 1'b1, 4'd3, 32'h100, 32'hFFFF_FFFF, 32'h1, 32'h20, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 4'd5, 32'h100, 32'hFFFF_FFFF, 32'h1, 32'h20, 1'b1, 1'b0);
      checkOutput("lit_blt_taken",  64'(busA.out_taken),  64'd1);
      checkOutput("lit_blt_target", 64'(busA.out_target), 64'h120);
      checkOutput("lit_blt_link",   64'(busA.out_link),   64'h104);
      idle(1'b1);
      checkOutput("lit_bltu_taken",  64'(busA.out_taken),  64'd0);
      checkOutput("lit_bltu_target", 64'(busA.out_target), 64'h104);

      // JALR bit-0 clearing and misalignment detection.
      applyStimulus(1'b0, 1'b1, 4'd8, 32'h200, 32'h1001, 32'h0, 32'h4, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 4'd8, 32'h200, 32'h1002, 32'h0, 32'h0, 1'b1, 1'b0);
      checkOutput("lit_jalr_target", 64'(busA.out_target),     64'h1004);
      checkOutput("lit_jalr_taken",  64'(busA.out_taken),      64'd1);
      checkOutput("lit_jalr_mis0",   64'(busA.out_misaligned), 64'd0);
      idle(1'b1);
      checkOutput("lit_jalr_mis1",   64'(busA.out_misaligned), 64'd1);

      // Three back-to-back BEQ at full throughput.
      applyStimulus(1'b1, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
      for (int i = 1; i <= 3; i++) begin
         applyStimulus(1'b0, 1'b1, 4'd1, 32'(i * 16), 32'h9, 32'h9, 32'h10, 1'b1, 1'b0);
         if (i > 1) checkOutput("lit_b2b_target", 64'(busA.out_target), 64'((i - 1) * 16 + 16));
      end
      idle(1'b1);
      checkOutput("lit_b2b_target3", 64'(busA.out_target), 64'h40);
      checkOutput("lit_b2b_br",      64'(statBrA),          64'd3);
      idle(1'b1);

      // Backpressure: result held for 4 cycles, then released in order.
      applyStimulus(1'b0, 1'b1, 4'd2, 32'h300, 32'h1, 32'h2, 32'h40, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b1, 4'd1, 32'h400, 32'h7, 32'h7, 32'h8, 1'b0, 1'b0);
         checkOutput("lit_hold_in_ready", 64'(busA.in_ready),   64'd0);
         checkOutput("lit_hold_target",   64'(busA.out_target), 64'h340);
      end
      applyStimulus(1'b0, 1'b1, 4'd1, 32'h400, 32'h7, 32'h7, 32'h8, 1'b1, 1'b0);
      checkOutput("lit_release_target", 64'(busA.out_target), 64'h340);
      idle(1'b1);
      checkOutput("lit_next_target", 64'(busA.out_target), 64'h408);
      checkOutput("lit_next_br",     64'(statBrA),          64'd5);
      idle(1'b1);

      // Flush while FULL with a new request pending, then while EMPTY.
      applyStimulus(1'b0, 1'b1, 4'd4, 32'h500, 32'h5, 32'h3, 32'h10, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 4'd1, 32'h0, 32'h1, 32'h1, 32'h0, 1'b0, 1'b1);
      checkOutput("lit_bge_target", 64'(busA.out_target), 64'h510);
      idle(1'b1);
      checkOutput("lit_flush_valid", 64'(busA.out_valid), 64'd0);
      checkOutput("lit_flush_br",    64'(statBrA),        64'd6);
      applyStimulus(1'b0, 1'b1, 4'd1, 32'h0, 32'h1, 32'h1, 32'h0, 1'b1, 1'b1);
      idle(1'b1);
      checkOutput("lit_flush2_valid", 64'(busA.out_valid), 64'd0);
      checkOutput("lit_flush2_br",    64'(statBrA),        64'd6);

      // Saturation of the 2-bit counters.
      for (int i = 0; i < 5; i++)
         applyStimulus(1'b0, 1'b1, 4'd2, 32'h600, 32'h1, 32'h0, 32'h100, 1'b1, 1'b0);
      idle(1'b1);
      checkOutput("lit_sat_tkB", 64'(statTkB), 64'd3);
      checkOutput("lit_sat_brB", 64'(statBrB), 64'd3);
      checkOutput("lit_sat_tkA", 64'(statTkA), 64'd11);

      // Reset in the middle of a stream.
      applyStimulus(1'b0, 1'b1, 4'd2, 32'h700, 32'h1, 32'h0, 32'h8, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 4'd2, 32'h700, 32'h1, 32'h0, 32'h8, 1'b0, 1'b0);
      checkOutput("lit_midrst_in_ready", 64'(busA.in_ready), 64'd1);
      idle(1'b0);
      checkOutput("lit_midrst_valid",  64'(busA.out_valid),      64'd0);
      checkOutput("lit_midrst_taken",  64'(busA.out_taken),      64'd0);
      checkOutput("lit_midrst_target", 64'(busA.out_target),     64'd0);
      checkOutput("lit_midrst_link",   64'(busA.out_link),       64'd0);
      checkOutput("lit_midrst_mis",    64'(busA.out_misaligned), 64'd0);
      checkOutput("lit_midrst_tkA",    64'(statTkA),             64'd0);
      checkOutput("lit_midrst_tkB",    64'(statTkB),             64'd0);

      // Randomized traffic with occasional flush and reset.
      for (int i = 0; i < 3000; i++) begin
         a   = $urandom;
         b   = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) == 0) ? $urandom : a + 32'($urandom_range(0, 2)) - 32'd1);
         r   = $urandom;
         imm = ($urandom_range(0, 1) == 0) ? $urandom : {{20{r[11]}}, r[11:0]};
         pc  = $urandom & (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : 32'hFFFF_FFFC);
         applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                       4'($urandom_range(0, 15)), pc, a, b, imm,
                       $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
      end
      idle(1'b1);
      idle(1'b1);
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
